// File: rtl/sysid_probe_master.sv
// rtl/sysid_probe_master.sv - Avalon-MM read master probing system ID and build timestamp
// Macro SYSID_PROBE_TS_CHECK_EN builds the timestamp read and comparison; undefined probes the ID only.
module sysid_probe_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1416924553,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        timeout_err
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST = 2'(READ_LATENCY - 1);
`ifdef SYSID_PROBE_TS_CHECK_EN
    localparam state_t AFTER_ID = RD_TS;
`else
    localparam state_t AFTER_ID = DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic        first_q, first_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        first_d     = 1'b0;
        id_d        = id_q;
        ts_d        = ts_q;
        busy_d      = busy_q;
        done_d      = done_q;
        match_d     = match_q;
        timeout_d   = timeout_q;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start || (first_q && AUTO_START)) begin
                    state_d    = RD_ID;
                    wait_cnt_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    match_d    = 1'b0;
                    timeout_d  = 1'b0;
                    id_d       = '0;
                    ts_d       = '0;
                end
            end
            RD_ID: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        id_d       = avm_readdata;
                        state_d    = AFTER_ID;
                        wait_cnt_d = '0;
                    end else begin
                        lat_cnt_d = '0;
                        state_d   = LAT_ID;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            LAT_ID: begin
                if (lat_cnt_q == LAT_LAST) begin
                    id_d       = avm_readdata;
                    state_d    = AFTER_ID;
                    wait_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
`ifdef SYSID_PROBE_TS_CHECK_EN
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        ts_d    = avm_readdata;
                        state_d = DONE;
                    end else begin
                        lat_cnt_d = '0;
                        state_d   = LAT_TS;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            LAT_TS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    ts_d    = avm_readdata;
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Flags resolve on the DONE-entry edge, using the value captured in the same cycle
        if (state_d == DONE && state_q != DONE) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = !timeout_d && (id_d == EXPECTED_ID);
`ifdef SYSID_PROBE_TS_CHECK_EN
            match_d = match_d && (ts_d == EXPECTED_TIMESTAMP);
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            first_q    <= 1'b1;
            id_q       <= '0;
            ts_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            first_q    <= first_d;
            id_q       <= id_d;
            ts_q       <= ts_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            match_q    <= match_d;
            timeout_q  <= timeout_d;
        end
    end

    assign id_value        = id_q;
    assign timestamp_value = ts_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign match           = match_q;
    assign timeout_err     = timeout_q;
endmodule
